// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of issue, write-back and register-file write-port signals for regfile_wb_scheduler.
// The master side drives requests; the slave side is the scheduler.
interface regfile_wb_scheduler_if;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        issue_ready;
    logic        hazard;

    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;

    logic        mem_wb_valid;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;
    logic        mem_wb_ready;

    logic        reg_wren;
    logic [4:0]  write_address;
    logic [31:0] write_data;

    logic        flush;
    logic [5:0]  outstanding;
    logic        wb_err;

    modport master (
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output mem_wb_valid, mem_wb_rd, mem_wb_data,
        output flush,
        input  issue_ready, hazard, alu_wb_ready, mem_wb_ready,
        input  reg_wren, write_address, write_data, outstanding, wb_err
    );

    modport slave (
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  mem_wb_valid, mem_wb_rd, mem_wb_data,
        input  flush,
        output issue_ready, hazard, alu_wb_ready, mem_wb_ready,
        output reg_wren, write_address, write_data, outstanding, wb_err
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Pending-register scoreboard with RAW/WAW issue stall and round-robin ALU/load write-back
// arbitration feeding a registered register-file write port.
module regfile_wb_scheduler (
    input  logic                   clk,
    input  logic                   reset,
    regfile_wb_scheduler_if.slave  bus
);

    logic [31:0] pending_r;
    logic [5:0]  outstanding_r;
    logic        favour_mem_r;
    logic        reg_wren_r;
    logic [4:0]  write_address_r;
    logic [31:0] write_data_r;
    logic        wb_err_r;

    logic        hazard_s;
    logic        issue_ready_s;
    logic        grant_alu_s;
    logic        grant_mem_s;
    logic        grant_any_s;
    logic [4:0]  grant_rd_s;
    logic [31:0] grant_data_s;
    logic        grant_write_s;
    logic        spurious_s;
    logic [31:0] set_mask_s;
    logic [31:0] clear_mask_s;
    logic [31:0] pending_next_s;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    // Operand hazard and issue acceptance from the current scoreboard.
    always_comb begin
        hazard_s      = pending_r[bus.rs1_addr] | pending_r[bus.rs2_addr];
        issue_ready_s = bus.issue_valid & ~hazard_s & ~pending_r[bus.issue_rd] & ~bus.flush;
    end

    // Round-robin grant; favour_mem_r names who wins a tie, and flush blocks both.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
        if (bus.flush) begin
            grant_alu_s = 1'b0;
            grant_mem_s = 1'b0;
        end else if (bus.alu_wb_valid && bus.mem_wb_valid) begin
            grant_mem_s = favour_mem_r;
            grant_alu_s = ~favour_mem_r;
        end else begin
            grant_alu_s = bus.alu_wb_valid;
            grant_mem_s = bus.mem_wb_valid;
        end
    end

    // Select the granted request's destination and data.
    always_comb begin
        grant_rd_s   = 5'd0;
        grant_data_s = 32'd0;
        case ({grant_alu_s, grant_mem_s})
            2'b10: begin
                grant_rd_s   = bus.alu_wb_rd;
                grant_data_s = bus.alu_wb_data;
            end
            2'b01: begin
                grant_rd_s   = bus.mem_wb_rd;
                grant_data_s = bus.mem_wb_data;
            end
            default: begin
                grant_rd_s   = 5'd0;
                grant_data_s = 32'd0;
            end
        endcase
        grant_any_s   = grant_alu_s | grant_mem_s;
        grant_write_s = grant_any_s & (grant_rd_s != 5'd0);
        spurious_s    = grant_write_s & ~pending_r[grant_rd_s];
    end

    // Next scoreboard: clear on committing write, set on accepted issue (set wins), flush empties.
    always_comb begin
        set_mask_s   = (issue_ready_s && (bus.issue_rd != 5'd0)) ? (32'd1 << bus.issue_rd) : 32'd0;
        clear_mask_s = reg_wren_r ? (32'd1 << write_address_r) : 32'd0;
        if (bus.flush) begin
            pending_next_s = 32'd0;
        end else begin
            pending_next_s = ((pending_r & ~clear_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
        end
    end

    // State and registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r       <= 32'd0;
            outstanding_r   <= 6'd0;
            favour_mem_r    <= 1'b1;
            reg_wren_r      <= 1'b0;
            write_address_r <= 5'd0;
            write_data_r    <= 32'd0;
            wb_err_r        <= 1'b0;
        end else begin
            pending_r     <= pending_next_s;
            outstanding_r <= popcount32(pending_next_s);
            reg_wren_r    <= grant_write_s;
            if (grant_any_s) begin
                favour_mem_r <= grant_alu_s;
            end
            if (grant_write_s) begin
                write_address_r <= grant_rd_s;
                write_data_r    <= grant_data_s;
            end
            if (spurious_s) begin
                wb_err_r <= 1'b1;
            end
        end
    end

    assign bus.hazard        = hazard_s;
    assign bus.issue_ready   = issue_ready_s;
    assign bus.alu_wb_ready  = grant_alu_s;
    assign bus.mem_wb_ready  = grant_mem_s;
    assign bus.reg_wren      = reg_wren_r;
    assign bus.write_address = write_address_r;
    assign bus.write_data    = write_data_r;
    assign bus.outstanding   = outstanding_r;
    assign bus.wb_err        = wb_err_r;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized and directed bench for regfile_wb_scheduler against an array-based scoreboard model.
module tb_regfile_wb_scheduler;

    logic clk;
    logic reset;
    regfile_wb_scheduler_if bus ();

    regfile_wb_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: which registers await a write, who won arbitration last, expected port.
    bit          m_pend [32];
    int          m_last;        // 1 = alu won last, 2 = mem won last
    bit          m_wren;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int model_count();
        int c = 0;
        foreach (m_pend[i]) c += m_pend[i];
        return c;
    endfunction

    function automatic void model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_last = 1;
        m_wren = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
        m_err  = 1'b0;
    endfunction

    function automatic logic [4:0] pick_rd();
        int q[$];
        for (int i = 1; i < 32; i++) if (m_pend[i]) q.push_back(i);
        if (q.size() == 0 || $urandom_range(0, 14) == 0) return 5'($urandom_range(0, 7));
        return 5'(q[$urandom_range(0, q.size() - 1)]);
    endfunction

    task automatic step(input bit rst, input bit fl, input bit iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit mv, input logic [4:0] mrd, input logic [31:0] md);
        bit          e_haz, e_ir;
        int          who;
        logic [4:0]  g_rd;
        logic [31:0] g_data;
        @(negedge clk);
        reset = rst;             bus.flush = fl;
        bus.issue_valid = iv;    bus.issue_rd = ird;
        bus.rs1_addr = r1;       bus.rs2_addr = r2;
        bus.alu_wb_valid = av;   bus.alu_wb_rd = ard;  bus.alu_wb_data = ad;
        bus.mem_wb_valid = mv;   bus.mem_wb_rd = mrd;  bus.mem_wb_data = md;
        #1;
        e_haz = m_pend[r1] || m_pend[r2];
        e_ir  = iv && !e_haz && !m_pend[ird] && !fl;
        who   = 0;
        if (!fl) begin
            if (av && mv) who = (m_last == 1) ? 2 : 1;
            else if (av)  who = 1;
            else if (mv)  who = 2;
        end
        chk("hazard", 32'(bus.hazard), 32'(e_haz));
        chk("issue_ready", 32'(bus.issue_ready), 32'(e_ir));
        chk("alu_wb_ready", 32'(bus.alu_wb_ready), 32'(who == 1));
        chk("mem_wb_ready", 32'(bus.mem_wb_ready), 32'(who == 2));
        @(posedge clk);
        g_rd   = (who == 1) ? ard : mrd;
        g_data = (who == 1) ? ad  : md;
        if (rst) begin
            model_reset();
        end else begin
            if (who != 0 && g_rd != 5'd0 && !m_pend[g_rd]) m_err = 1'b1;
            if (m_wren) m_pend[m_addr] = 1'b0;
            if (e_ir && ird != 5'd0) m_pend[ird] = 1'b1;
            if (fl) foreach (m_pend[i]) m_pend[i] = 1'b0;
            if (who != 0) m_last = who;
            m_wren = (who != 0) && (g_rd != 5'd0);
            if (m_wren) begin
                m_addr = g_rd;
                m_data = g_data;
            end
        end
        #1;
        chk("reg_wren", 32'(bus.reg_wren), 32'(m_wren));
        chk("write_address", 32'(bus.write_address), 32'(m_addr));
        chk("write_data", bus.write_data, m_data);
        chk("outstanding", 32'(bus.outstanding), 32'(model_count()));
        chk("wb_err", 32'(bus.wb_err), 32'(m_err));
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        step(0, 0, 0, 5'd0, r1, r2, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    bit          r_rst, r_fl, r_iv, r_av, r_mv;
    logic [4:0]  r_ird, r_r1, r_r2, r_ard, r_mrd;
    logic [31:0] r_ad, r_md;

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
        bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
        bus.alu_wb_valid = 1'b0; bus.alu_wb_rd = 5'd0; bus.alu_wb_data = 32'd0;
        bus.mem_wb_valid = 1'b0; bus.mem_wb_rd = 5'd0; bus.mem_wb_data = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wren", 32'(bus.reg_wren), 32'd0);
        chk("rst_outstanding", 32'(bus.outstanding), 32'd0);
        chk("rst_wb_err", 32'(bus.wb_err), 32'd0);
        chk("rst_addr", 32'(bus.write_address), 32'd0);

        // RAW hazard then ALU write-back of r5
        step(0, 0, 1, 5'd5, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(0, 0, 1, 5'd6, 5'd5, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("d26_no_issue", 32'(bus.outstanding), 32'd1);
        step(0, 0, 0, 5'd0, 5'd5, 5'd0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
        chk("d26_data", bus.write_data, 32'h0000_1234);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd0);

        // Simultaneous requests after reset: mem first, then alu
        do_reset();
        step(0, 0, 1, 5'd7, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(0, 0, 1, 5'd9, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd7, 32'hA7, 1, 5'd9, 32'hB9);
        chk("d27_first_addr", 32'(bus.write_address), 32'd9);
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd7, 32'hA7, 0, 5'd0, 32'd0);
        chk("d27_out1", 32'(bus.outstanding), 32'd1);
        idle(5'd0, 5'd0);
        chk("d27_out0", 32'(bus.outstanding), 32'd0);

        // WAW: second issue of r3 waits for its write
        step(0, 0, 1, 5'd3, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(0, 0, 1, 5'd3, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(0, 0, 1, 5'd3, 5'd0, 5'd0, 0, 5'd0, 32'd0, 1, 5'd3, 32'h33);
        step(0, 0, 1, 5'd3, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(0, 0, 1, 5'd3, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // Spurious write sets sticky wb_err
        do_reset();
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, 1, 5'd12, 32'hC12);
        chk("d29_err", 32'(bus.wb_err), 32'd1);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Flush with three pending and blocked requests
        do_reset();
        step(0, 0, 1, 5'd1, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(0, 0, 1, 5'd2, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(0, 0, 1, 5'd4, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(0, 1, 1, 5'd8, 5'd1, 5'd2, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
        chk("d30_out", 32'(bus.outstanding), 32'd0);
        idle(5'd1, 5'd4);

        // rd = 0 on both issue and write-back
        step(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 5'd0, 32'hDEAD, 0, 5'd0, 32'd0);
        chk("d31_wren", 32'(bus.reg_wren), 32'd0);
        idle(5'd0, 5'd0);

        // Reset while a write is registered
        step(0, 0, 1, 5'd10, 5'd0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd10, 32'h10, 0, 5'd0, 32'd0);
        do_reset();

        for (int n = 0; n < 1500; n++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_fl  = ($urandom_range(0, 29) == 0);
            r_iv  = $urandom_range(0, 1) != 0;
            r_ird = 5'($urandom_range(0, 7));
            r_r1  = 5'($urandom_range(0, 7));
            r_r2  = 5'($urandom_range(0, 7));
            r_av  = $urandom_range(0, 1) != 0;
            r_ard = pick_rd();
            r_ad  = $urandom;
            r_mv  = $urandom_range(0, 1) != 0;
            r_mrd = pick_rd();
            r_md  = $urandom;
            step(r_rst, r_fl, r_iv, r_ird, r_r1, r_r2, r_av, r_ard, r_ad, r_mv, r_mrd, r_md);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
